// File: rtl/oam_pkg.sv
// oam_pkg: shared sizing for the two-bank OAM SRAM
package oam_pkg;
  localparam int OAM_WORDS_DEF = 80;
  localparam int OAM_DW_DEF    = 8;
  localparam int WORD_W        = 7;
endpackage

// File: rtl/oam_sram_bank.sv
// oam_sram_bank: one OAM bank with valid bits, registered read data and inverted tri-state bus
module oam_sram_bank
  import oam_pkg::*;
#(
  parameter int WORDS = OAM_WORDS_DEF,
  parameter int DW    = OAM_DW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] word,
  input  logic              ncs,
  input  logic              nrd,
  inout  wire  [DW-1:0]     nd,
  output logic              uninit,
  output logic              range_err
);
  logic [DW-1:0]    mem [WORDS];
  logic [DW-1:0]    rd_q, rd_d;
  logic [WORDS-1:0] valid_q, valid_d;
  logic             uninit_q, uninit_d, rerr_q, rerr_d;
  logic             in_rng, wr, rd;
  always_comb begin
    in_rng   = int'(word) < WORDS;
    wr       = !ncs && nrd && in_rng;
    rd       = !ncs && !nrd;
    rd_d     = rd ? (in_rng ? mem[word] : '1) : rd_q;
    valid_d  = valid_q;
    if (wr) valid_d[word] = 1'b1;
    uninit_d = rd && in_rng && !valid_q[word];
    rerr_d   = !ncs && !in_rng;
  end
  always_ff @(posedge clk)
    if (wr) mem[word] <= ~nd;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q     <= '0;
      valid_q  <= '0;
      uninit_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      valid_q  <= valid_d;
      uninit_q <= uninit_d;
      rerr_q   <= rerr_d;
    end
  // The bus enable is purely combinational so it survives reset and releases instantly.
  assign nd        = rd ? ~rd_q : 'z;
  assign uninit    = uninit_q;
  assign range_err = rerr_q;
endmodule

// File: rtl/oam_sram.sv
// oam_sram: even/odd byte OAM banks sharing one word address
module oam_sram
  import oam_pkg::*;
#(
  parameter int OAM_WORDS = OAM_WORDS_DEF,
  parameter int OAM_DW    = OAM_DW_DEF
) (
  input  logic              oam_clk,
  input  logic              nreset,
  input  logic [7:0]        oam_a,
  input  logic              oam_a_ncs,
  input  logic              oam_b_ncs,
  input  logic              oam_a_cpu_nrd,
  input  logic              oam_b_cpu_nrd,
  inout  wire  [OAM_DW-1:0] oam_a_nd,
  inout  wire  [OAM_DW-1:0] oam_b_nd,
  output logic              uninit_rd,
  output logic              range_err
);
  logic [WORD_W-1:0] word;
  logic              un_a, un_b, re_a, re_b;
  assign word = oam_a[7:1];
  oam_sram_bank #(.WORDS(OAM_WORDS), .DW(OAM_DW)) u_a (
    .clk(oam_clk), .rst_n(nreset), .word(word), .ncs(oam_a_ncs), .nrd(oam_a_cpu_nrd),
    .nd(oam_a_nd), .uninit(un_a), .range_err(re_a)
  );
  oam_sram_bank #(.WORDS(OAM_WORDS), .DW(OAM_DW)) u_b (
    .clk(oam_clk), .rst_n(nreset), .word(word), .ncs(oam_b_ncs), .nrd(oam_b_cpu_nrd),
    .nd(oam_b_nd), .uninit(un_b), .range_err(re_b)
  );
  assign uninit_rd = un_a | un_b;
  assign range_err = re_a | re_b;
endmodule

// File: doc/oam_sram.md
OAM_SRAM -- requirements
Module: oam_sram

Interface
REQ-001 SHALL have parameter: OAM_WORDS, 80, words per bank (bank A even bytes, bank B odd bytes).
REQ-002 SHALL have parameter: OAM_DW, 8, data width per bank.
REQ-003 SHALL have port: oam_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port: nreset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: oam_a  input  8  byte address; word index = oam_a[7:1]; oam_a[0] ignored (bank chosen by chip-selects).
REQ-006 SHALL have ports: oam_a_ncs, oam_b_ncs  input  1 each  active-low bank selects.
REQ-007 SHALL have ports: oam_a_cpu_nrd, oam_b_cpu_nrd  input  1 each  active-low read enables per bank.
REQ-008 SHALL have ports: oam_a_nd, oam_b_nd  inout  8 each  inverted data buses (bus value = ~data).
REQ-009 SHALL have port: uninit_rd  output  1  one-cycle pulse: a read captured a never-written word.
REQ-010 SHALL have port: range_err  output  1  one-cycle pulse: an access was selected with word index >= OAM_WORDS.

Function
REQ-011 SHALL store two banks of OAM_WORDS x OAM_DW bits; memory contents are not reset.
REQ-012 SHALL, per bank, at rising oam_clk with ncs=0 and nrd=1 and word in range, write mem[word] <= ~nd (write cycle).
REQ-013 SHALL, per bank, at rising oam_clk with ncs=0 and nrd=0, capture rd_q <= mem[word] (read cycle); out-of-range word captures 0xFF.
REQ-014 SHALL drive nd = ~rd_q combinationally while ncs=0 and nrd=0, else high-Z; release takes zero oam_clk cycles.
REQ-015 SHALL hold rd_q between read cycles; read latency is one rising edge (data of edge N visible after edge N).
REQ-016 SHALL allow both banks selected in the same cycle, independently read or written (sprite-scan paired read).
REQ-017 SHALL ignore a bank whose ncs=1 (no write, rd_q unchanged, bus high-Z).
REQ-018 SHALL drop out-of-range writes with no memory change.
REQ-019 SHALL keep a valid bit per word per bank, set on write; read of a word with valid=0 SHALL assert uninit_rd for the cycle after the capturing edge.
REQ-020 SHALL assert range_err for the cycle after any edge where a selected bank had word >= OAM_WORDS; both flags are registered, cleared next edge unless re-triggered.
REQ-021 SHALL return on read the data written at the immediately preceding edge (write at N, read at N+1 returns new value; no bypass needed within one edge).
REQ-022 SHALL treat z/x bits on nd during a write as stored value (no filtering).

Reset
REQ-023 SHALL, on nreset=0, asynchronously clear rd_q (both banks) to 0x00, all valid bits to 0, uninit_rd and range_err to 0.
REQ-024 SHALL, on reset mid-read, keep nd driven ~0x00=0xFF while ncs=0 and nrd=0 (enable is combinational, not reset).
REQ-025 SHALL preserve memory contents across reset; first edge after nreset rises operates normally.

Structure
REQ-026 SHALL place OAM_WORDS, OAM_DW defaults and the word-index width (7) in shared package oam_pkg.
REQ-027 SHALL implement one sub-module oam_sram_bank (memory, valid bits, rd_q, tri-state driver) instantiated twice; top combines error flags by OR.

Verification
REQ-028 SHALL cover: reset, write A word 0x05 with nd=0x5A (data 0xA5), read A word 0x05 -> oam_a_nd=0x5A after edge, uninit_rd=0.
REQ-029 SHALL cover: both banks selected, write A=0x12, B=0x34 at oam_a=0x20, then paired read -> A bus 0xED, B bus 0xCB same cycle.
REQ-030 SHALL cover: read never-written B word 0x10 after reset -> uninit_rd=1 for exactly one cycle.
REQ-031 SHALL cover: write oam_a=0xA0 (word 0x50) -> range_err pulse, no store; read it -> rd_q=0xFF, bus 0x00.
REQ-032 SHALL cover: nreset pulsed between write and read of word 0x00 -> stored data intact, valid cleared, uninit_rd=1 on read.
REQ-033 SHALL cover: nrd deasserted mid-cycle -> bus high-Z immediately, rd_q retained and re-driven on next nrd=0 without new edge.
